// File: rtl/sif_xa_req_queue.sv
// sif_xa_req_queue: captures XA write/read strobes into a small FIFO and
// replays them one at a time onto the WA side with an ack handshake.
// WA read data is returned to the XA side as a single-cycle pulse.
// Optional build macro: SIF_XA_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module sif_xa_req_queue #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          xa_wr_st,
  input  logic          xa_rd_st,
  input  logic [AW-1:0] xa_addr,
  input  logic [DW-1:0] xa_data_wr,
  output logic          xa_busy,
  output logic [DW-1:0] xa_data_rd,
  output logic          xa_rd_vld,
  output logic          wa_wr_st,
  output logic          wa_rd_st,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data_wr,
  input  logic          wa_ack,
  input  logic [DW-1:0] wa_data_rd,
  input  logic          wa_rd_vld,
  output logic          illegal_err
`ifdef SIF_XA_ERR_CNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          op_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;

  logic any_st;
  logic full;
  logic push;
  logic pop;
  logic reject;
  req_t push_req;
  req_t head;

  // Push/pop qualification and rejection of illegal or overflowing strobes
  assign any_st         = xa_wr_st | xa_rd_st;
  assign full           = (count == CW'(DEPTH));
  assign push           = (xa_wr_st ^ xa_rd_st) & ~full;
  assign reject         = (xa_wr_st & xa_rd_st) | (any_st & full);
  assign pop            = (state == IDLE) && (count != '0);
  assign xa_busy        = full;
  assign push_req.op_wr = xa_wr_st;
  assign push_req.addr  = xa_addr;
  assign push_req.data  = xa_wr_st ? xa_data_wr : '0;
  assign head           = mem[rd_ptr];

  // Request storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // WA replay FSM: one transaction outstanding, strobes held until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wa_wr_st   <= 1'b0;
      wa_rd_st   <= 1'b0;
      wa_addr    <= '0;
      wa_data_wr <= '0;
      xa_data_rd <= '0;
      xa_rd_vld  <= 1'b0;
    end else begin
      xa_rd_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            wa_addr    <= head.addr;
            wa_data_wr <= head.data;
            wa_wr_st   <= head.op_wr;
            wa_rd_st   <= ~head.op_wr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (wa_ack) begin
            wa_wr_st <= 1'b0;
            wa_rd_st <= 1'b0;
            state    <= wa_wr_st ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (wa_rd_vld) begin
            xa_data_rd <= wa_data_rd;
            xa_rd_vld  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rejected strobe indication, one cycle after the offending edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_err <= 1'b0;
    end else begin
      illegal_err <= reject;
    end
  end

`ifdef SIF_XA_ERR_CNT_EN
  // Saturating count of illegal_err pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (illegal_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sif_xa_req_queue.sv
// Directed testbench for sif_xa_req_queue (default parameters AW=8, DW=16, DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sif_xa_req_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        xa_wr_st, xa_rd_st;
  logic [7:0]  xa_addr;
  logic [15:0] xa_data_wr;
  logic        xa_busy;
  logic [15:0] xa_data_rd;
  logic        xa_rd_vld;
  logic        wa_wr_st, wa_rd_st;
  logic [7:0]  wa_addr;
  logic [15:0] wa_data_wr;
  logic        wa_ack;
  logic [15:0] wa_data_rd;
  logic        wa_rd_vld;
  logic        illegal_err;
`ifdef SIF_XA_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  sif_xa_req_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .xa_wr_st    (xa_wr_st),
    .xa_rd_st    (xa_rd_st),
    .xa_addr     (xa_addr),
    .xa_data_wr  (xa_data_wr),
    .xa_busy     (xa_busy),
    .xa_data_rd  (xa_data_rd),
    .xa_rd_vld   (xa_rd_vld),
    .wa_wr_st    (wa_wr_st),
    .wa_rd_st    (wa_rd_st),
    .wa_addr     (wa_addr),
    .wa_data_wr  (wa_data_wr),
    .wa_ack      (wa_ack),
    .wa_data_rd  (wa_data_rd),
    .wa_rd_vld   (wa_rd_vld),
    .illegal_err (illegal_err)
`ifdef SIF_XA_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_a [5];

  initial begin
    rst_n = 1'b0; xa_wr_st = 1'b0; xa_rd_st = 1'b0; xa_addr = '0; xa_data_wr = '0;
    wa_ack = 1'b0; wa_data_rd = '0; wa_rd_vld = 1'b0;
    step(); step();
    // Reset state
    check("rst_wa_wr_st", 32'(wa_wr_st), 32'd0);
    check("rst_wa_rd_st", 32'(wa_rd_st), 32'd0);
    check("rst_busy", 32'(xa_busy), 32'd0);
    check("rst_rd_vld", 32'(xa_rd_vld), 32'd0);
    check("rst_data_rd", 32'(xa_data_rd), 32'd0);
    check("rst_illegal", 32'(illegal_err), 32'd0);
`ifdef SIF_XA_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // 1: single write, ack on third strobe cycle
    xa_wr_st = 1'b1; xa_addr = 8'h10; xa_data_wr = 16'hA5A5;
    step();
    xa_wr_st = 1'b0;
    check("t1_no_strobe_yet", 32'(wa_wr_st), 32'd0);
    step();
    check("t1_wr_st_c1", 32'(wa_wr_st), 32'd1);
    check("t1_rd_st_c1", 32'(wa_rd_st), 32'd0);
    check("t1_addr", 32'(wa_addr), 32'h10);
    check("t1_data", 32'(wa_data_wr), 32'hA5A5);
    step();
    check("t1_wr_st_c2", 32'(wa_wr_st), 32'd1);
    step();
    check("t1_wr_st_c3", 32'(wa_wr_st), 32'd1);
    wa_ack = 1'b1;
    step();
    wa_ack = 1'b0;
    check("t1_wr_st_drop", 32'(wa_wr_st), 32'd0);
    step();
    check("t1_no_reissue", 32'(wa_wr_st), 32'd0);

    // 2: read, data returned two cycles after ack
    xa_rd_st = 1'b1; xa_addr = 8'h22;
    step();
    xa_rd_st = 1'b0;
    step();
    check("t2_rd_st", 32'(wa_rd_st), 32'd1);
    check("t2_wr_st", 32'(wa_wr_st), 32'd0);
    check("t2_addr", 32'(wa_addr), 32'h22);
    wa_ack = 1'b1;
    step();
    wa_ack = 1'b0;
    check("t2_rd_st_drop", 32'(wa_rd_st), 32'd0);
    step();
    check("t2_no_early_vld", 32'(xa_rd_vld), 32'd0);
    wa_rd_vld = 1'b1; wa_data_rd = 16'h1234;
    step();
    wa_rd_vld = 1'b0; wa_data_rd = 16'h0000;
    check("t2_rd_vld", 32'(xa_rd_vld), 32'd1);
    check("t2_data_rd", 32'(xa_data_rd), 32'h1234);
    step();
    check("t2_rd_vld_pulse", 32'(xa_rd_vld), 32'd0);
    check("t2_data_hold", 32'(xa_data_rd), 32'h1234);

    // 4: both strobes high is rejected
    xa_wr_st = 1'b1; xa_rd_st = 1'b1; xa_addr = 8'h55; xa_data_wr = 16'h5555;
    step();
    xa_wr_st = 1'b0; xa_rd_st = 1'b0;
    check("t4_illegal", 32'(illegal_err), 32'd1);
    step();
    check("t4_illegal_pulse", 32'(illegal_err), 32'd0);
    check("t4_no_wr", 32'(wa_wr_st), 32'd0);
    check("t4_no_rd", 32'(wa_rd_st), 32'd0);
`ifdef SIF_XA_ERR_CNT_EN
    check("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif
    step();
    check("t4_still_idle", 32'(wa_wr_st | wa_rd_st), 32'd0);

    // 3/6: fill with ack low (one in flight + DEPTH queued), overflow, then
    // push on the pop edge and drain in order across pointer wrap
    for (int i = 0; i < 5; i++) begin
      xa_wr_st = 1'b1; xa_addr = 8'(8'h30 + i); xa_data_wr = 16'(16'h1000 + i);
      step();
      if (i == 3) check("t3_not_full", 32'(xa_busy), 32'd0);
    end
    check("t3_busy", 32'(xa_busy), 32'd1);
    xa_addr = 8'h35; xa_data_wr = 16'h1005;
    step();
    xa_wr_st = 1'b0;
    check("t3_ovf_illegal", 32'(illegal_err), 32'd1);
    check("t3_busy_hold", 32'(xa_busy), 32'd1);
    check("t3_head_addr", 32'(wa_addr), 32'h30);
    step();
    check("t3_ovf_pulse", 32'(illegal_err), 32'd0);
`ifdef SIF_XA_ERR_CNT_EN
    check("t3_err_cnt", 32'(err_cnt), 32'd2);
`endif
    wa_ack = 1'b1;
    step();
    wa_ack = 1'b0;
    check("t3_w0_drop", 32'(wa_wr_st), 32'd0);
    check("t3_full_idle", 32'(xa_busy), 32'd1);
    step();
    check("t3_w1_st", 32'(wa_wr_st), 32'd1);
    check("t3_w1_addr", 32'(wa_addr), 32'h31);
    check("t3_after_pop", 32'(xa_busy), 32'd0);
    wa_ack = 1'b1;
    step();
    wa_ack = 1'b0;
    xa_wr_st = 1'b1; xa_addr = 8'h36; xa_data_wr = 16'h1006;
    step();
    xa_wr_st = 1'b0;
    check("t6_pop_addr", 32'(wa_addr), 32'h32);
    check("t6_push_pop_busy", 32'(xa_busy), 32'd0);
    xa_wr_st = 1'b1; xa_addr = 8'h37; xa_data_wr = 16'h1007;
    step();
    xa_wr_st = 1'b0;
    check("t6_refull", 32'(xa_busy), 32'd1);
    exp_a[0] = 8'h32; exp_a[1] = 8'h33; exp_a[2] = 8'h34; exp_a[3] = 8'h36; exp_a[4] = 8'h37;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t6_drain%0d_st", k), 32'(wa_wr_st), 32'd1);
      check($sformatf("t6_drain%0d_addr", k), 32'(wa_addr), 32'(exp_a[k]));
      check($sformatf("t6_drain%0d_data", k), 32'(wa_data_wr), 32'(16'h1000 + 16'(exp_a[k] - 8'h30)));
      wa_ack = 1'b1;
      step();
      wa_ack = 1'b0;
      check($sformatf("t6_drain%0d_drop", k), 32'(wa_wr_st), 32'd0);
      step();
    end
    check("t6_empty_idle", 32'(wa_wr_st | wa_rd_st), 32'd0);
    check("t6_empty_busy", 32'(xa_busy), 32'd0);

    // 5: async reset while waiting for read data
    xa_rd_st = 1'b1; xa_addr = 8'h44;
    step();
    xa_rd_st = 1'b0;
    step();
    check("t5_rd_st", 32'(wa_rd_st), 32'd1);
    wa_ack = 1'b1;
    step();
    wa_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_data_rd", 32'(xa_data_rd), 32'd0);
    check("t5_rst_rd_st", 32'(wa_rd_st), 32'd0);
    check("t5_rst_addr", 32'(wa_addr), 32'd0);
    step();
    rst_n = 1'b1;
    wa_rd_vld = 1'b1; wa_data_rd = 16'hBEEF;
    step();
    wa_rd_vld = 1'b0; wa_data_rd = 16'h0000;
    check("t5_no_rd_vld", 32'(xa_rd_vld), 32'd0);
    check("t5_data_rd_zero", 32'(xa_data_rd), 32'd0);
    step();
    check("t5_no_wa_activity", 32'(wa_wr_st | wa_rd_st), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
